// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_ctrl
// Brief    : Two-road six-phase light scheduler on a prescaled 1 s tick,
//            with countdown and pedestrian-request NS-green shortening.
// Revision : 1.0
// ============================================================================
module traffic_light_ctrl #(
    parameter logic [25:0] TICK_MAX    = 26'd50_000_000,
    parameter logic [7:0]  GREEN_NS_S  = 8'd20,
    parameter logic [7:0]  GREEN_EW_S  = 8'd10,
    parameter logic [7:0]  YELLOW_S    = 8'd3,
    parameter logic [7:0]  ALLRED_S    = 8'd1,
    parameter logic [7:0]  PED_SHORT_S = 8'd5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       ped_req,
    output logic       tick,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [7:0] remain,
    output logic       ped_pending
);

    localparam logic [25:0] c_CNT_LAST = TICK_MAX - 26'd1;
    localparam logic [2:0]  c_RED      = 3'b100;
    localparam logic [2:0]  c_YELLOW   = 3'b010;
    localparam logic [2:0]  c_GREEN    = 3'b001;

    typedef enum logic [2:0] {
        S_NS_GREEN  = 3'd0,
        S_NS_YELLOW = 3'd1,
        S_ALLRED1   = 3'd2,
        S_EW_GREEN  = 3'd3,
        S_EW_YELLOW = 3'd4,
        S_ALLRED2   = 3'd5
    } state_t;

    state_t      r_state;
    logic [25:0] r_cnt;
    logic [7:0]  r_remain;
    logic [2:0]  r_ns_light;
    logic [2:0]  r_ew_light;
    logic        r_ped_pending;

    state_t      w_next_state;
    logic [7:0]  w_next_dur;
    logic [2:0]  w_next_ns;
    logic [2:0]  w_next_ew;
    logic        w_tick;
    logic        w_advance;
    logic        w_shorten;
    logic        w_enter_ew;

    // Reset gate keeps tick low while reset is held, even when TICK_MAX is 1.
    assign w_tick     = en && !rst && (r_cnt == c_CNT_LAST);
    assign w_advance  = w_tick && (r_remain == 8'd1);
    assign w_shorten  = en && (r_state == S_NS_GREEN) && r_ped_pending
                        && (r_remain > PED_SHORT_S);
    assign w_enter_ew = w_advance && (r_state == S_ALLRED1);

    always_comb begin
        w_next_state = S_NS_GREEN;
        w_next_dur   = GREEN_NS_S;
        w_next_ns    = c_GREEN;
        w_next_ew    = c_RED;
        case (r_state)
            S_NS_GREEN: begin
                w_next_state = S_NS_YELLOW;
                w_next_dur   = YELLOW_S;
                w_next_ns    = c_YELLOW;
                w_next_ew    = c_RED;
            end
            S_NS_YELLOW: begin
                w_next_state = S_ALLRED1;
                w_next_dur   = ALLRED_S;
                w_next_ns    = c_RED;
                w_next_ew    = c_RED;
            end
            S_ALLRED1: begin
                w_next_state = S_EW_GREEN;
                w_next_dur   = GREEN_EW_S;
                w_next_ns    = c_RED;
                w_next_ew    = c_GREEN;
            end
            S_EW_GREEN: begin
                w_next_state = S_EW_YELLOW;
                w_next_dur   = YELLOW_S;
                w_next_ns    = c_RED;
                w_next_ew    = c_YELLOW;
            end
            S_EW_YELLOW: begin
                w_next_state = S_ALLRED2;
                w_next_dur   = ALLRED_S;
                w_next_ns    = c_RED;
                w_next_ew    = c_RED;
            end
            default: begin
                w_next_state = S_NS_GREEN;
                w_next_dur   = GREEN_NS_S;
                w_next_ns    = c_GREEN;
                w_next_ew    = c_RED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 26'd0;
        end else if (en) begin
            r_cnt <= (r_cnt == c_CNT_LAST) ? 26'd0 : r_cnt + 26'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_NS_GREEN;
            r_remain      <= GREEN_NS_S;
            r_ns_light    <= c_GREEN;
            r_ew_light    <= c_RED;
            r_ped_pending <= 1'b0;
        end else begin
            // A new request in the serving cycle outranks the clear.
            if (ped_req) begin
                r_ped_pending <= 1'b1;
            end else if (w_enter_ew) begin
                r_ped_pending <= 1'b0;
            end

            // Shortening needs remain > PED_SHORT_S >= 1, so it never meets an advance.
            if (w_shorten) begin
                r_remain <= PED_SHORT_S;
            end else if (w_advance) begin
                r_state    <= w_next_state;
                r_remain   <= w_next_dur;
                r_ns_light <= w_next_ns;
                r_ew_light <= w_next_ew;
            end else if (w_tick) begin
                r_remain <= r_remain - 8'd1;
            end
        end
    end

    assign tick        = w_tick;
    assign ns_light    = r_ns_light;
    assign ew_light    = r_ew_light;
    assign remain      = r_remain;
    assign ped_pending = r_ped_pending;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_light_ctrl
// Brief    : Directed checkpoints queued by the stimulus, popped by a monitor.
// Revision : 1.0
// ============================================================================
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       ped_req = 1'b0;
    logic       tick;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [7:0] remain;
    logic       ped_pending;

    traffic_light_ctrl #(
        .TICK_MAX   (26'd4),
        .GREEN_NS_S (8'd5),
        .GREEN_EW_S (8'd3),
        .YELLOW_S   (8'd2),
        .ALLRED_S   (8'd1),
        .PED_SHORT_S(8'd2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ped_req    (ped_req),
        .tick       (tick),
        .ns_light   (ns_light),
        .ew_light   (ew_light),
        .remain     (remain),
        .ped_pending(ped_pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int         cyc;
        logic [2:0] ns;
        logic [2:0] ew;
        logic [7:0] rem;
        logic       pend;
        logic       tck;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    base = 0;
    int    n_checks = 0;
    int    n_pass = 0;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    // Monitor: outputs are sampled mid-cycle, away from the driving edge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e  = q.pop_front();
                nm = nq.pop_front();
                n_checks++;
                if (e.cyc != cyc) begin
                    $display("FAIL %s: expectation for cycle %0d reached only at cycle %0d", nm, e.cyc, cyc);
                end else if (ns_light === e.ns && ew_light === e.ew && remain === e.rem
                             && ped_pending === e.pend && tick === e.tck) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s (cyc %0d): got ns=%b ew=%b remain=%0d pend=%b tick=%b, want ns=%b ew=%b remain=%0d pend=%b tick=%b",
                             nm, cyc, ns_light, ew_light, remain, ped_pending, tick,
                             e.ns, e.ew, e.rem, e.pend, e.tck);
                end
            end
        end
    end

    task automatic expect_at(input string nm, input int r, input logic [2:0] ns,
                             input logic [2:0] ew, input logic [7:0] rem,
                             input logic pend, input logic tck);
        exp_t e;
        e.cyc  = base + r;
        e.ns   = ns;
        e.ew   = ew;
        e.rem  = rem;
        e.pend = pend;
        e.tck  = tck;
        q.push_back(e);
        nq.push_back(nm);
    endtask

    // Returns 1 time unit after the edge that starts relative cycle r.
    task automatic at_rel(input int r);
        while (cyc < base + r) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic full_reset();
        @(posedge clk);
        #1;
        rst     = 1'b1;
        en      = 1'b0;
        ped_req = 1'b0;
        base    = cyc;
        expect_at("reset_state", 0, G, R, 8'd5, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        en   = 1'b1;
        base = cyc;
    endtask

    initial begin
        // Plain schedule: 20/8/4/12/8/4 clocks per phase.
        full_reset();
        expect_at("run_start",     0, G, R, 8'd5, 1'b0, 1'b0);
        expect_at("run_tick1",     3, G, R, 8'd5, 1'b0, 1'b1);
        expect_at("run_rem4",      4, G, R, 8'd4, 1'b0, 1'b0);
        expect_at("run_rem1",     16, G, R, 8'd1, 1'b0, 1'b0);
        expect_at("run_nsg_end",  19, G, R, 8'd1, 1'b0, 1'b1);
        expect_at("run_nsy",      20, Y, R, 8'd2, 1'b0, 1'b0);
        expect_at("run_nsy_end",  27, Y, R, 8'd1, 1'b0, 1'b1);
        expect_at("run_allred1",  28, R, R, 8'd1, 1'b0, 1'b0);
        expect_at("run_ar1_end",  31, R, R, 8'd1, 1'b0, 1'b1);
        expect_at("run_ewg",      32, R, G, 8'd3, 1'b0, 1'b0);
        expect_at("run_ewy",      44, R, Y, 8'd2, 1'b0, 1'b0);
        expect_at("run_allred2",  52, R, R, 8'd1, 1'b0, 1'b0);
        expect_at("run_nsg_again",56, G, R, 8'd5, 1'b0, 1'b0);
        expect_at("run_rem4_again",63, G, R, 8'd4, 1'b0, 1'b1);
        at_rel(64);

        // One-clock pedestrian pulse early in NS green.
        full_reset();
        expect_at("ped_pre",       1, G, R, 8'd5, 1'b0, 1'b0);
        expect_at("ped_latched",   2, G, R, 8'd5, 1'b1, 1'b0);
        expect_at("ped_shortened", 3, G, R, 8'd2, 1'b1, 1'b1);
        expect_at("ped_rem1",      4, G, R, 8'd1, 1'b1, 1'b0);
        expect_at("ped_nsg_end",   7, G, R, 8'd1, 1'b1, 1'b1);
        expect_at("ped_nsy",       8, Y, R, 8'd2, 1'b1, 1'b0);
        expect_at("ped_allred1",  16, R, R, 8'd1, 1'b1, 1'b0);
        expect_at("ped_ar1_end",  19, R, R, 8'd1, 1'b1, 1'b1);
        expect_at("ped_cleared",  20, R, G, 8'd3, 1'b0, 1'b0);
        at_rel(1);
        ped_req = 1'b1;
        at_rel(2);
        ped_req = 1'b0;
        at_rel(21);

        // Request held across EW-green entry: set beats clear, next NS green shortened.
        full_reset();
        expect_at("hold_ar1",      28, R, R, 8'd1, 1'b0, 1'b0);
        expect_at("hold_latched",  30, R, R, 8'd1, 1'b1, 1'b0);
        expect_at("hold_ewg",      32, R, G, 8'd3, 1'b1, 1'b0);
        expect_at("hold_after",    33, R, G, 8'd3, 1'b1, 1'b0);
        expect_at("hold_ewy",      44, R, Y, 8'd2, 1'b1, 1'b0);
        expect_at("hold_allred2",  52, R, R, 8'd1, 1'b1, 1'b0);
        expect_at("hold_nsg",      56, G, R, 8'd5, 1'b1, 1'b0);
        expect_at("hold_short",    57, G, R, 8'd2, 1'b1, 1'b0);
        expect_at("hold_tick",     59, G, R, 8'd2, 1'b1, 1'b1);
        expect_at("hold_rem1",     60, G, R, 8'd1, 1'b1, 1'b0);
        expect_at("hold_nsy",      64, Y, R, 8'd2, 1'b1, 1'b0);
        at_rel(29);
        ped_req = 1'b1;
        at_rel(33);
        ped_req = 1'b0;
        at_rel(65);

        // Late request (no reload), enable freeze in NS yellow, then async reset in EW yellow.
        full_reset();
        expect_at("late_noreload", 13, G, R, 8'd2, 1'b1, 1'b0);
        expect_at("late_rem1",     16, G, R, 8'd1, 1'b1, 1'b0);
        expect_at("late_nsy",      20, Y, R, 8'd2, 1'b1, 1'b0);
        expect_at("frz_start",     22, Y, R, 8'd2, 1'b1, 1'b0);
        expect_at("frz_no_tick",   23, Y, R, 8'd2, 1'b1, 1'b0);
        expect_at("frz_end",       31, Y, R, 8'd2, 1'b1, 1'b0);
        expect_at("resume",        32, Y, R, 8'd2, 1'b1, 1'b0);
        expect_at("resume_tick",   33, Y, R, 8'd2, 1'b1, 1'b1);
        expect_at("resume_rem1",   34, Y, R, 8'd1, 1'b1, 1'b0);
        expect_at("resume_ar1",    38, R, R, 8'd1, 1'b1, 1'b0);
        expect_at("resume_ewg",    42, R, G, 8'd3, 1'b0, 1'b0);
        expect_at("pre_rst_ewy",   55, R, Y, 8'd2, 1'b1, 1'b0);
        at_rel(12);
        ped_req = 1'b1;
        at_rel(13);
        ped_req = 1'b0;
        at_rel(22);
        en = 1'b0;
        at_rel(32);
        en = 1'b1;
        at_rel(50);
        ped_req = 1'b1;
        at_rel(51);
        ped_req = 1'b0;
        at_rel(56);
        rst = 1'b1;
        expect_at("async_reset",   56, G, R, 8'd5, 1'b0, 1'b0);
        at_rel(57);
        rst  = 1'b0;
        base = cyc;
        expect_at("rst_restart",    0, G, R, 8'd5, 1'b0, 1'b0);
        expect_at("rst_first_tick", 3, G, R, 8'd5, 1'b0, 1'b1);
        expect_at("rst_rem4",       4, G, R, 8'd4, 1'b0, 1'b0);
        at_rel(5);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            $display("FAIL drain: %0d expectations never reached the monitor", q.size());
            n_checks += q.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
